// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_unit
// Brief    : IF-stage PC sequencer and IF/ID pipeline register. Issues fetch
//            addresses to a one-cycle-latency instruction memory, applies
//            EX-stage branch/jump redirects (squash, IF/ID clear, ID/EX
//            flush), load-use stall hold and ECALL/EBREAK halt.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             stall,
  input  logic             halt_req,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  imem_addr,
  output logic             imem_req,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             flush_id_ex,
  output logic             misalign_err,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_valid_q, inflight_valid_d;
  logic [XLEN-1:0]  if_id_pc_q, if_id_pc_d;
  logic [31:0]      if_id_instr_q, if_id_instr_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic             misalign_err_q, misalign_err_d;

  logic             w_redirect;
  logic [XLEN-1:0]  w_raw_target;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_pc_plus4;

  // Redirect request decode: jump outranks a simultaneous taken branch.
  always_comb begin
    w_redirect   = branch_taken | jump;
    w_raw_target = jump ? jump_target : branch_target;
    // bit0 is always dropped; a set bit1 is a misaligned target and is
    // dropped as well, so the fetch address is always word aligned.
    w_target     = {w_raw_target[XLEN-1:2], 2'b00};
    w_pc_plus4   = pc_q + C_PC_STEP;
  end

  // Next-state and IF/ID update: redirect > halt > stall > normal fetch.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_valid_d    = if_id_valid_q;
    redirect_cnt_d   = redirect_cnt_q;
    misalign_err_d   = 1'b0;

    if (state_q != ST_HALT) begin
      if (w_redirect) begin
        pc_d             = w_target;
        inflight_valid_d = 1'b0;
        if_id_valid_d    = 1'b0;
        if_id_instr_d    = NOP_INSTR;
        state_d          = ST_FLUSH;
        misalign_err_d   = w_raw_target[1];
        if (redirect_cnt_q != {CNT_W{1'b1}}) begin
          redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
        end
      end else if (state_q == ST_FLUSH) begin
        // Response arriving now belongs to the squashed path: drop it.
        if_id_valid_d    = 1'b0;
        if_id_instr_d    = NOP_INSTR;
        inflight_pc_d    = pc_q;
        inflight_valid_d = 1'b1;
        pc_d             = w_pc_plus4;
        state_d          = ST_RUN;
      end else if (halt_req) begin
        if_id_valid_d    = 1'b0;
        if_id_instr_d    = NOP_INSTR;
        state_d          = ST_HALT;
      end else if (!stall) begin
        if_id_pc_d       = inflight_pc_q;
        if_id_instr_d    = imem_rdata;
        if_id_valid_d    = inflight_valid_q;
        inflight_pc_d    = pc_q;
        inflight_valid_d = 1'b1;
        pc_d             = w_pc_plus4;
      end
    end
  end

  // State and pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_FLUSH;
      pc_q             <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
      if_id_pc_q       <= '0;
      if_id_instr_q    <= NOP_INSTR;
      if_id_valid_q    <= 1'b0;
      redirect_cnt_q   <= '0;
      misalign_err_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_valid_q    <= if_id_valid_d;
      redirect_cnt_q   <= redirect_cnt_d;
      misalign_err_q   <= misalign_err_d;
    end
  end

  // While stalled the pending word is re-read so it is fresh when the stall drops.
  assign imem_addr    = (stall && (state_q == ST_RUN)) ? inflight_pc_q : pc_q;
  assign imem_req     = (state_q != ST_HALT);
  assign flush_id_ex  = w_redirect && (state_q != ST_HALT);
  assign halted       = (state_q == ST_HALT);
  assign if_id_pc     = if_id_pc_q;
  assign if_id_pc4    = if_id_pc_q + C_PC_STEP;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_valid  = if_id_valid_q;
  assign misalign_err = misalign_err_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect_unit
// Brief    : Self-checking bench for fetch_redirect_unit. A reference model
//            keeps the expected in-order instruction stream as a queue of PCs
//            (restarted on reset/redirect); a monitor pops it whenever the ID
//            stage consumes a valid IF/ID entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_unit;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        halt_req;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        flush_id_ex;
  logic        misalign_err;
  logic        halted;
  logic [15:0] redirect_cnt;

  fetch_redirect_unit dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .halt_req      (halt_req),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .if_id_pc      (if_id_pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .flush_id_ex   (flush_id_ex),
    .misalign_err  (misalign_err),
    .halted        (halted),
    .redirect_cnt  (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address A reads as A|0x13.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr | 32'h13;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_pc;
  logic [15:0] m_cnt;
  bit          m_mis;
  bit          m_halted;
  bit          m_flush;
  bit          mon_en;
  logic [31:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for the coming cycle; a redirect restarts the expected stream.
  task automatic set_in(input logic bt, input logic [31:0] bta, input logic j,
                        input logic [31:0] jt, input logic st, input logic hr);
    branch_taken  = bt;
    branch_target = bta;
    jump          = j;
    jump_target   = jt;
    stall         = st;
    halt_req      = hr;
    if ((bt || j) && !m_halted) begin
      exp_q.delete();
      last_pc = j ? {jt[31:2], 2'b00} : {bta[31:2], 2'b00};
      exp_q.push_back(last_pc);
    end
  endtask

  task automatic idle();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Advance one clock and apply the architectural effect of this cycle's inputs.
  task automatic tick();
    bit red;
    while (exp_q.size() < 8) begin
      last_pc = last_pc + 32'd4;
      exp_q.push_back(last_pc);
    end
    @(posedge clk);
    red = branch_taken || jump;
    if (!m_halted) begin
      m_mis = red && (jump ? jump_target[1] : branch_target[1]);
      if (red && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (!red && halt_req && !m_flush) m_halted = 1'b1;
      m_flush = red;
    end else begin
      m_mis = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b1;
    exp_q.delete();
    last_pc  = C_RESET_PC;
    exp_q.push_back(C_RESET_PC);
    m_cnt    = 16'd0;
    m_mis    = 1'b0;
    m_halted = 1'b0;
    m_flush  = 1'b1;
    mon_en   = 1'b1;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int n = 0;
    while (imem_addr !== a && n < 50) begin
      tick();
      n++;
    end
    check("reach_imem_addr", imem_addr, a);
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
      default: return 32'($urandom_range(0, 1023));
    endcase
  endfunction

  // Monitor: per-cycle control outputs plus in-order stream scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, (branch_taken || jump) && !m_halted});
      check("imem_req", {31'b0, imem_req}, {31'b0, !m_halted});
      check("halted", {31'b0, halted}, {31'b0, m_halted});
      check("redirect_cnt", {16'b0, redirect_cnt}, {16'b0, m_cnt});
      check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
      if (if_id_valid && !stall && !branch_taken && !jump) begin
        if (exp_q.size() == 0) begin
          check("stream_underflow", if_id_pc, 32'hDEAD_BEEF);
        end else begin
          mon_e = exp_q.pop_front();
          check("stream_pc", if_id_pc, mon_e);
          check("stream_instr", if_id_instr, mon_e | 32'h13);
          check("stream_pc4", if_id_pc4, mon_e + 32'd4);
        end
      end
    end
  end

  logic [15:0] cnt_hold;

  initial begin
    mon_en   = 1'b0;
    m_halted = 1'b0;
    m_cnt    = 16'd0;
    last_pc  = C_RESET_PC;
    rst      = 1'b1;
    idle();
    #2 rst = 1'b0;
    #1;
    // Asynchronous reset values before any clock edge.
    check("rst_if_id_valid", {31'b0, if_id_valid}, 32'd0);
    check("rst_if_id_instr", if_id_instr, C_NOP);
    check("rst_if_id_pc", if_id_pc, 32'h0);
    check("rst_redirect_cnt", {16'b0, redirect_cnt}, 32'd0);
    check("rst_imem_addr", imem_addr, C_RESET_PC);

    // Reset release: first valid instruction two cycles later.
    apply_reset();
    check("c0_valid", {31'b0, if_id_valid}, 32'd0);
    check("c0_imem_addr", imem_addr, 32'h0);
    tick();
    check("c1_valid", {31'b0, if_id_valid}, 32'd0);
    check("c1_imem_addr", imem_addr, 32'h4);
    tick();
    check("c2_valid", {31'b0, if_id_valid}, 32'd1);
    check("c2_pc", if_id_pc, 32'h0);
    check("c2_instr", if_id_instr, 32'h13);
    tick();
    check("c3_pc", if_id_pc, 32'h4);
    tick();
    check("c4_pc", if_id_pc, 32'h8);

    // Taken branch to 0x100 while fetching 0x20.
    wait_addr(32'h20);
    set_in(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("br_flush", {31'b0, flush_id_ex}, 32'd1);
    tick();
    idle();
    check("br_imem_addr", imem_addr, 32'h100);
    check("br_bubble1", {31'b0, if_id_valid}, 32'd0);
    check("br_cnt", {16'b0, redirect_cnt}, 32'd1);
    tick();
    check("br_bubble2", {31'b0, if_id_valid}, 32'd0);
    tick();
    check("br_tgt_valid", {31'b0, if_id_valid}, 32'd1);
    check("br_tgt_pc", if_id_pc, 32'h100);

    // Stall for 3 cycles with pc=0x40.
    set_in(1'b0, 32'h0, 1'b1, 32'h30, 1'b0, 1'b0);
    tick();
    idle();
    wait_addr(32'h40);
    check("st_pre_pc", if_id_pc, 32'h38);
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      check("st_imem_addr", imem_addr, 32'h3C);
      check("st_hold_pc", if_id_pc, 32'h38);
      check("st_hold_instr", if_id_instr, 32'h3B);
      tick();
    end
    idle();
    #1;
    check("st_rel_imem_addr", imem_addr, 32'h40);
    check("st_rel_pc", if_id_pc, 32'h38);
    tick();
    check("st_after1_pc", if_id_pc, 32'h3C);
    check("st_after1_instr", if_id_instr, 32'h3F);
    tick();
    check("st_after2_pc", if_id_pc, 32'h40);

    // Jump 0x202 with branch 0x300: jump wins, misaligned, one increment.
    set_in(1'b1, 32'h300, 1'b1, 32'h202, 1'b0, 1'b0);
    tick();
    idle();
    check("mis_imem_addr", imem_addr, 32'h200);
    check("mis_err", {31'b0, misalign_err}, 32'd1);
    check("mis_cnt", {16'b0, redirect_cnt}, 32'd3);
    tick();
    check("mis_err_drop", {31'b0, misalign_err}, 32'd0);
    check("mis_cnt_hold", {16'b0, redirect_cnt}, 32'd3);
    tick();
    check("mis_tgt_pc", if_id_pc, 32'h200);

    // Randomized traffic: redirects (incl. simultaneous and near-wrap) and stalls.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      set_in(r < 8, rand_target(), (r >= 5) && (r < 12), rand_target(),
             $urandom_range(0, 4) == 0, 1'b0);
      tick();
    end
    idle();

    // halt_req together with a taken branch: redirect wins, no halt.
    set_in(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    check("hb_halted", {31'b0, halted}, 32'd0);
    check("hb_imem_addr", imem_addr, 32'h80);
    check("hb_cnt", {16'b0, redirect_cnt}, {16'b0, m_cnt});
    tick();
    tick();
    check("hb_tgt_pc", if_id_pc, 32'h80);

    // Lone halt_req: frozen until reset regardless of inputs.
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    cnt_hold = m_cnt;
    for (int k = 0; k < 6; k++) begin
      check("h_halted", {31'b0, halted}, 32'd1);
      check("h_imem_req", {31'b0, imem_req}, 32'd0);
      check("h_valid", {31'b0, if_id_valid}, 32'd0);
      check("h_instr", if_id_instr, C_NOP);
      check("h_pc", if_id_pc, 32'h80);
      check("h_imem_addr", imem_addr, 32'h88);
      check("h_cnt", {16'b0, redirect_cnt}, {16'b0, cnt_hold});
      set_in($urandom_range(0, 1) == 1, rand_target(), $urandom_range(0, 1) == 1,
             rand_target(), $urandom_range(0, 1) == 1, 1'b1);
      tick();
    end
    apply_reset();
    check("h_rel_halted", {31'b0, halted}, 32'd0);
    check("h_rel_imem_req", {31'b0, imem_req}, 32'd1);

    // Asynchronous reset in the middle of FLUSH.
    repeat (4) tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 1'b0);
    tick();
    idle();
    check("mf_pre_addr", imem_addr, 32'h1000);
    check("mf_pre_pc", if_id_pc, 32'h8);
    check("mf_pre_cnt", {16'b0, redirect_cnt}, 32'd1);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mf_rst_addr", imem_addr, C_RESET_PC);
    check("mf_rst_pc", if_id_pc, 32'h0);
    check("mf_rst_instr", if_id_instr, C_NOP);
    check("mf_rst_valid", {31'b0, if_id_valid}, 32'd0);
    check("mf_rst_cnt", {16'b0, redirect_cnt}, 32'd0);
    check("mf_rst_mis", {31'b0, misalign_err}, 32'd0);
    #20 rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
IF-stage PC sequencer and IF/ID pipeline register for the pipelined RV32I core. It owns the PC and issues addresses to a synchronous instruction memory with one-cycle read latency. It consumes the EX-stage branch decision (branch_taken, produced from func3 and the ALU flags) plus jump requests, and performs the redirect: it squashes the wrong-path fetch, clears IF/ID, and raises the ID/EX flush. It also implements load-use stall hold and ECALL/EBREAK halt.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction word (ADDI x0,x0,0) placed in IF/ID when not valid
CNT_W, 16, width of redirect_cnt

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
branch_taken  in  1  EX-stage branch decision, already qualified by branch
branch_target  in  XLEN  EX-stage branch target
jump  in  1  EX-stage JAL/JALR
jump_target  in  XLEN  EX-stage jump target
stall  in  1  load-use hold from hazard unit
halt_req  in  1  ECALL/EBREAK decoded in ID
imem_rdata  in  32  word for the address issued the previous cycle
imem_addr  out  XLEN  fetch address
imem_req  out  1  fetch enable
if_id_pc  out  XLEN  PC of the IF/ID instruction
if_id_pc4  out  XLEN  if_id_pc+4
if_id_instr  out  32  IF/ID instruction
if_id_valid  out  1  IF/ID holds a real instruction
flush_id_ex  out  1  combinational; squash ID/EX this cycle
misalign_err  out  1  one-cycle pulse when redirect target[1]=1
halted  out  1  unit is in HALT
redirect_cnt  out  CNT_W  count of redirects taken, saturating

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, inflight_pc=0, inflight_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, redirect_cnt=0, misalign_err=0, state=FLUSH. Reset asserted mid-operation aborts everything immediately. The first valid IF/ID instruction is RESET_PC, appearing 2 cycles after rst deassertion.
- States: RUN, FLUSH, HALT.
  - FLUSH: the imem response arriving this cycle is wrong-path or undefined and is discarded. IF/ID takes NOP_INSTR with valid=0. Fetch continues with pc<=pc+4. Next state is RUN. stall is ignored in FLUSH.
  - RUN: IF/ID <= {inflight_pc, imem_rdata, valid=inflight_valid}. inflight_pc<=pc, inflight_valid<=1, pc<=pc+4.
  - HALT: imem_req=0, pc and IF/ID frozen, if_id_valid=0. HALT is left only by reset.
- redirect = branch_taken | jump. If both are set, jump_target wins.
- Redirect target: raw target with bit0 cleared. If raw target bit1=1, misalign_err pulses for that cycle and bits[1:0] are also cleared.
- Priority, highest first: redirect > halt_req > stall > normal.
- Redirect in cycle N, from any state except HALT:
  - flush_id_ex=1 in cycle N.
  - At the edge: pc<=target, inflight_valid<=0, if_id_valid<=0, if_id_instr<=NOP_INSTR, state<=FLUSH, redirect_cnt+1 (holds at all-ones).
  - imem_addr=target in cycle N+1. The target instruction is in IF/ID at N+3, giving a 2-bubble penalty.
- Back-to-back redirects (N and N+1): the second wins and re-enters FLUSH.
- stall in RUN: pc, inflight_pc, and IF/ID hold. imem_addr=inflight_pc so the pending word is re-read and available when the stall drops. flush_id_ex=0 (the hazard unit inserts the bubble).
- halt_req in RUN without redirect: IF/ID <= invalid NOP, state<=HALT. A redirect in the same cycle overrides halt, because the halting instruction is younger and squashed.
- imem_addr = stall&&state==RUN ? inflight_pc : pc. imem_req = state!=HALT.
- pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0) with no error. if_id_pc4 is combinational from if_id_pc.

Test Plan:
- Reset release with RESET_PC=0 and the imem model returning addr|0x13: if_id_pc = 0,4,8 on cycles 2,3,4, and if_id_valid rises at cycle 2.
- Redirect: branch_taken=1 with target 0x100 while fetching 0x20 -> flush_id_ex=1 that cycle, next imem_addr=0x100, if_id_valid=0 for 2 cycles, then if_id_pc=0x100, redirect_cnt=1.
- Stall held 3 cycles during RUN at pc=0x40 -> IF/ID instruction/pc unchanged and imem_addr=0x3C throughout; on release if_id_pc=0x3C, then 0x40, with no word lost or duplicated.
- jump to 0x202 and branch_taken to 0x300 in the same cycle -> pc=0x200, misalign_err=1 for one cycle, redirect_cnt+1 (one increment).
- halt_req together with branch_taken to 0x80 -> no halt, redirect to 0x80. A later lone halt_req -> halted=1, imem_req=0, IF/ID frozen until rst pulse.
- rst asserted mid-FLUSH -> outputs at reset values immediately, without waiting for a clock edge.
